// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the sequential shift-add multiplier.
// Contents:
//   state_t - FSM state encoding (IDLE, RUN, DONE; 2'd3 is unused)
//   clog2   - ceiling log2, used to size the iteration counter
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, evaluated at elaboration time for parameter sizing.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mult_cneg.sv
// mult_cneg
// Combinational conditional two's-complement negate.
// Ports:
//   neg    in   1      1 = output the negation of value, 0 = pass through
//   value  in   WIDTH  operand
//   result out  WIDTH  value or -value
module mult_cneg #(
    parameter int WIDTH = 8
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] result
);

    // Negating zero wraps back to zero, so a zero magnitude never
    // turns into a "negative zero".
    always_comb begin
        result = neg ? (~value + WIDTH'(1)) : value;
    end

endmodule

// File: rtl/mult_seq.sv
// mult_seq
// Parametrised sequential shift-add multiplier with signed/unsigned mode.
// Operands are converted to magnitudes on start, multiplied over WIDTH
// cycles, and the product sign is applied when the result is registered.
// Ports:
//   clk          in   1        rising-edge clock
//   rst          in   1        synchronous active-high reset
//   start        in   1        request, accepted in IDLE or DONE
//   signed_mode  in   1        1 = two's complement operands/result
//   a            in   WIDTH    multiplicand
//   b            in   WIDTH    multiplier
//   busy         out  1        high while computing
//   done         out  1        result valid (pulse or hold, see DONE_HOLD)
//   r            out  2*WIDTH  product, held until the next completion
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit DONE_HOLD = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] r
);

    localparam int CW = clog2(WIDTH + 1);

    state_t               state;
    state_t               next_state;
    logic                 load;
    logic                 finish;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   r_fixed;
    logic                 neg_res;
    logic                 mode;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // Magnitudes of the operands; in signed mode the most-negative value
    // maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    mult_cneg #(.WIDTH(WIDTH)) u_neg_a (
        .neg    (signed_mode & a[WIDTH-1]),
        .value  (a),
        .result (a_mag)
    );

    mult_cneg #(.WIDTH(WIDTH)) u_neg_b (
        .neg    (signed_mode & b[WIDTH-1]),
        .value  (b),
        .result (b_mag)
    );

    // Accumulator after this cycle's partial product; on the final
    // iteration this is the complete unsigned magnitude of the product.
    always_comb begin
        acc_sum = acc + (mplier[0] ? mcand : '0);
    end

    // Apply the product sign to the final magnitude.
    mult_cneg #(.WIDTH(2*WIDTH)) u_neg_r (
        .neg    (mode & neg_res),
        .value  (acc_sum),
        .result (r_fixed)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode. A start in DONE re-enters RUN
    // directly so back-to-back operations lose no cycle.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (count == CW'(1)) begin
                    finish     = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = ST_RUN;
                end else if (!DONE_HOLD) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture on load, one shift-add step per RUN
    // cycle, and result capture on the last step. r is left untouched
    // by load so the previous product stays visible during the next run.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            mode    <= 1'b0;
            r       <= '0;
        end else if (load) begin
            count   <= CW'(WIDTH);
            mcand   <= {{WIDTH{1'b0}}, a_mag};
            mplier  <= b_mag;
            acc     <= '0;
            neg_res <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            mode    <= signed_mode;
        end else if (state == ST_RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
            if (finish) begin
                r <= r_fixed;
            end
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq
// Self-checking bench for mult_seq: an 8-bit hold-style instance driven
// from a vector table plus hand-written sequences, and a 16-bit
// pulse-style instance for the single-cycle done behaviour.
module tb_mult_seq;

    typedef struct {
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] expR;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8;
    logic        sm8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] r8;

    logic        start16;
    logic        sm16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        busy16;
    logic        done16;
    logic [31:0] r16;

    int testsRun    = 0;
    int testsFailed = 0;

    vec_t vecs [12];

    // Free-running clock shared by both instances.
    always #5 clk = ~clk;

    mult_seq #(.WIDTH(8), .DONE_HOLD(1'b1)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .signed_mode (sm8),
        .a           (a8),
        .b           (b8),
        .busy        (busy8),
        .done        (done8),
        .r           (r8)
    );

    mult_seq #(.WIDTH(16), .DONE_HOLD(1'b0)) dut16 (
        .clk         (clk),
        .rst         (rst),
        .start       (start16),
        .signed_mode (sm16),
        .a           (a16),
        .b           (b16),
        .busy        (busy16),
        .done        (done16),
        .r           (r16)
    );

    // Compares one observed value with its expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Pulses start on the 8-bit instance for one edge; called at a negedge
    // and returns at the negedge after the start was sampled.
    task automatic applyStimulus(input logic sm, input logic [7:0] av,
                                 input logic [7:0] bv);
        start8 = 1'b1;
        sm8    = sm;
        a8     = av;
        b8     = bv;
        @(negedge clk);
        start8 = 1'b0;
        a8     = 8'hxx;
        b8     = 8'hxx;
        sm8    = ~sm;
    endtask

    // Counts busy cycles until done, bounded so a stuck DUT cannot hang.
    task automatic waitDone8(output int busyCycles, output bit timedOut);
        busyCycles = 0;
        timedOut   = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (done8) begin
                timedOut = 1'b0;
                break;
            end
            if (busy8) busyCycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int  cyc;
        bit  tmo;
        int  doneSeen;

        vecs[0]  = '{1'b0, 8'h03, 8'h04, 16'h000C};
        vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[2]  = '{1'b1, 8'hFD, 8'h04, 16'hFFF4};
        vecs[3]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[4]  = '{1'b1, 8'h00, 8'h80, 16'h0000};
        vecs[5]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vecs[6]  = '{1'b0, 8'hFF, 8'h02, 16'h01FE};
        vecs[7]  = '{1'b1, 8'hFF, 8'h02, 16'hFFFE};
        vecs[8]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[9]  = '{1'b1, 8'h05, 8'hFD, 16'hFFF1};
        vecs[10] = '{1'b0, 8'hAA, 8'h55, 16'h3872};
        vecs[11] = '{1'b1, 8'h7F, 8'h80, 16'hC080};

        rst     = 1'b1;
        start8  = 1'b0;
        sm8     = 1'b0;
        a8      = '0;
        b8      = '0;
        start16 = 1'b0;
        sm16    = 1'b0;
        a16     = '0;
        b16     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("reset busy", 32'(busy8), 32'd0);
        checkOutput("reset done", 32'(done8), 32'd0);
        checkOutput("reset r", 32'(r8), 32'd0);

        // Basic unsigned product with level-style done persisting.
        applyStimulus(1'b0, 8'd3, 8'd4);
        waitDone8(cyc, tmo);
        checkOutput("t1 timeout", 32'(tmo), 32'd0);
        checkOutput("t1 busy cycles", 32'(cyc), 32'd8);
        checkOutput("t1 r", 32'(r8), 32'h000C);
        repeat (10) @(negedge clk);
        checkOutput("t1 done held", 32'(done8), 32'd1);
        checkOutput("t1 busy after", 32'(busy8), 32'd0);

        // Table of products, each issued from the DONE state.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].sm, vecs[i].a, vecs[i].b);
            waitDone8(cyc, tmo);
            checkOutput($sformatf("vec%0d timeout", i), 32'(tmo), 32'd0);
            checkOutput($sformatf("vec%0d busy cycles", i), 32'(cyc), 32'd8);
            checkOutput($sformatf("vec%0d r", i), 32'(r8), 32'(vecs[i].expR));
        end

        // Start during RUN is ignored.
        applyStimulus(1'b0, 8'd7, 8'd6);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 8'd1, 8'd1);
        waitDone8(cyc, tmo);
        checkOutput("t4 timeout", 32'(tmo), 32'd0);
        checkOutput("t4 remaining busy", 32'(cyc), 32'd5);
        checkOutput("t4 r", 32'(r8), 32'd42);

        // Back-to-back start in the DONE cycle.
        applyStimulus(1'b0, 8'd2, 8'd5);
        checkOutput("t4b done dropped", 32'(done8), 32'd0);
        checkOutput("t4b busy rose", 32'(busy8), 32'd1);
        checkOutput("t4b r held", 32'(r8), 32'd42);
        waitDone8(cyc, tmo);
        checkOutput("t4b timeout", 32'(tmo), 32'd0);
        checkOutput("t4b busy cycles", 32'(cyc), 32'd8);
        checkOutput("t4b r", 32'(r8), 32'd10);

        // Reset in the middle of RUN abandons the operation.
        applyStimulus(1'b0, 8'd9, 8'd9);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t5 busy", 32'(busy8), 32'd0);
        checkOutput("t5 done", 32'(done8), 32'd0);
        checkOutput("t5 r", 32'(r8), 32'd0);
        doneSeen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) doneSeen++;
        end
        checkOutput("t5 stays idle", 32'(doneSeen), 32'd0);
        applyStimulus(1'b0, 8'd2, 8'd3);
        waitDone8(cyc, tmo);
        checkOutput("t5 timeout", 32'(tmo), 32'd0);
        checkOutput("t5 r after", 32'(r8), 32'd6);

        // 16-bit pulse-style done.
        start16 = 1'b1;
        sm16    = 1'b1;
        a16     = 16'hFFFF;
        b16     = 16'h7FFF;
        @(negedge clk);
        start16 = 1'b0;
        cyc = 0;
        tmo = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (done16) begin
                tmo = 1'b0;
                break;
            end
            if (busy16) cyc++;
            @(negedge clk);
        end
        checkOutput("t6 timeout", 32'(tmo), 32'd0);
        checkOutput("t6 busy cycles", 32'(cyc), 32'd16);
        checkOutput("t6 r", r16, 32'hFFFF8001);
        @(negedge clk);
        checkOutput("t6 done pulse", 32'(done16), 32'd0);
        checkOutput("t6 idle busy", 32'(busy16), 32'd0);
        checkOutput("t6 r held", r16, 32'hFFFF8001);
        doneSeen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done16) doneSeen++;
        end
        checkOutput("t6 no further done", 32'(doneSeen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
Parametrised sequential shift-add multiplier and the successor to the fixed 8-bit mult block. It adds generic operand width and a per-operation signed/unsigned mode. It has a full start/busy/done handshake with back-to-back issue, a selectable done style (pulse or hold), and a synchronous reset. It sits in the adder/multiplier arithmetic library as the standard multi-cycle multiply unit for datapaths that trade latency for area.

Parameters:
WIDTH, 8, operand width in bits; legal range 2 or more; result is 2*WIDTH bits.
DONE_HOLD, 1, 1 = done stays high until the next accepted start (legacy level-style done); 0 = done is a single-cycle pulse.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when the unit is idle or done.
signed_mode  input  1  1 = a, b and r are two's complement; 0 = unsigned; sampled with start.
a  input  WIDTH  multiplicand; sampled with start.
b  input  WIDTH  multiplier; sampled with start.
busy  output  1  high while computing.
done  output  1  result valid indication (style set by DONE_HOLD).
r  output  2*WIDTH  product; registered; holds its last value until the next completion.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, busy=0, done=0, r=0, internal counter and accumulator cleared. Reset has priority over every other event, including mid-RUN; any operation in flight is abandoned and produces no done.
- States are IDLE, RUN and DONE. busy=1 only in RUN; done=1 only in DONE.
- IDLE or DONE with start=1 at edge N:
  - latch signed_mode.
  - latch magnitudes |a| and |b| (signed) or raw a and b (unsigned).
  - latch result sign = a[MSB]^b[MSB] (signed) or 0 (unsigned).
  - clear the accumulator, set count=WIDTH, go to RUN.
- If start=0 in DONE: DONE_HOLD=1 stays in DONE; DONE_HOLD=0 goes to IDLE after one cycle.
- RUN: on each edge, if the current multiplier LSB is 1, add the shifted multiplicand to the 2*WIDTH accumulator. Then shift the multiplier right and the multiplicand left, and decrement count.
- On the edge where count reaches 0 (edge N+WIDTH):
  - r <= accumulator, or its two's complement negation if the result sign is 1.
  - go to DONE.
- Latency: start sampled at edge N gives done=1 and r valid in the cycle after edge N+WIDTH (WIDTH cycles). Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- start during RUN is ignored; a, b and signed_mode may change freely during RUN without effect.
- Start accepted in DONE: done drops and busy rises on the same edge; r keeps the old result until the new completion.
- Arithmetic rules:
  - Magnitudes are WIDTH-bit unsigned; |most-negative| = 2^(WIDTH-1) fits.
  - The accumulator is 2*WIDTH bits and never overflows, for both modes at all operand values.
  - Zero operand: r=0 with sign forced positive, never negative zero (inherent in two's complement).
- Counter width is clog2(WIDTH+1).

Decomposition:
- Shared package mult_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 is illegal and goes to IDLE).
  - a clog2 function used for the counter width.
- One sub-module, mult_cneg: combinational conditional two's-complement negate, parametrised on width. It is instantiated for a, for b (WIDTH) and for the result fix-up (2*WIDTH).
- The FSM, counter and datapath live in mult_seq.

Test Plan:
1. WIDTH=8, unsigned, a=3, b=4, start for one cycle -> busy for 8 cycles, then done=1 and r=12 (16'h000C); done still 1 ten cycles later (DONE_HOLD=1).
2. WIDTH=8, unsigned, a=255, b=255 -> r=65025 (16'hFE01); signed, a=8'hFD (-3), b=4 -> r=16'hFFF4 (-12).
3. WIDTH=8, signed, a=b=8'h80 (-128) -> r=16'h4000 (+16384); signed, a=0, b=8'h80 -> r=0.
4. Start with a=7, b=6. Assert start again at cycle 3 with a=1, b=1 -> second request ignored; r=42 at cycle 8. Then start in the DONE cycle with a=2, b=5 -> done deasserts on that edge and r=10 eight cycles later.
5. Start with a=9, b=9; assert rst for one cycle at cycle 4 -> the next cycle shows busy=0, done=0, r=0; no done follows; a new start with a=2, b=3 gives r=6.
6. WIDTH=16, DONE_HOLD=0, signed, a=16'hFFFF (-1), b=16'h7FFF -> done pulses for exactly one cycle after 16 busy cycles; r=32'hFFFF8001; the state returns to IDLE.
